// File: rtl/frv_dmem_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// frv_dmem_responder : SRAM-backed dmem bus target, wait states, 2-entry resp FIFO.
// Optional random grant stall: define FRV_DMEM_RESP_RANDOM_STALL_EN.
// Revision: 1.0
// ----------------------------------------------------------------------------
module frv_dmem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        dmem_req,
  input  logic        dmem_wen,
  input  logic [3:0]  dmem_strb,
  input  logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_addr,
  output logic        dmem_gnt,
  output logic        dmem_recv,
  input  logic        dmem_ack,
  output logic        dmem_error,
  output logic [31:0] dmem_rdata
);

  localparam int unsigned C_AW    = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  C_WAIT  = 4'(WAIT_CYCLES);
  localparam logic [31:0] C_BYTES = 32'(DEPTH_WORDS * 4);

  logic [31:0]     mem_q [DEPTH_WORDS];
  logic [32:0]     fifo_q [2];
  logic            wr_ptr_q, rd_ptr_q;
  logic [1:0]      count_q, count_d;
  logic [3:0]      wait_q, wait_d;

  logic [31:0]     w_offset;
  logic            w_in_range;
  logic [C_AW-1:0] w_idx;
  logic            w_push, w_pop, w_stall;
  logic [32:0]     w_resp;

  // Word range check on the full byte offset; offset[1:0] never pushes past DEPTH*4.
  assign w_offset   = dmem_addr - BASE_ADDR;
  assign w_in_range = (w_offset < C_BYTES);
  assign w_idx      = w_offset[C_AW+1:2];

`ifdef FRV_DMEM_RESP_RANDOM_STALL_EN
  logic [15:0] lfsr_q;
  always_ff @(posedge g_clk) begin
    if (!g_resetn) lfsr_q <= 16'hACE1;
    else           lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  end
  assign w_stall = lfsr_q[0];
`else
  assign w_stall = 1'b0;
`endif

  // A full buffer refuses new work even on a cycle where it pops.
  assign dmem_gnt = g_resetn && dmem_req && (wait_q == C_WAIT) &&
                    (count_q != 2'd2) && !w_stall;
  assign w_push   = dmem_req && dmem_gnt;
  assign w_pop    = dmem_recv && dmem_ack;

  always_comb begin
    wait_d = wait_q;
    if (!dmem_req || dmem_gnt) wait_d = 4'd0;
    else if (wait_q != C_WAIT) wait_d = wait_q + 4'd1;
  end

  always_comb begin
    count_d = count_q;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    w_resp = {1'b0, mem_q[w_idx]};
    if (!w_in_range)   w_resp = {1'b1, 32'h0};
    else if (dmem_wen) w_resp = {1'b0, 32'h0};
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      wait_q   <= 4'd0;
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      wait_q  <= wait_d;
      count_q <= count_d;
      if (w_push) wr_ptr_q <= ~wr_ptr_q;
      if (w_pop)  rd_ptr_q <= ~rd_ptr_q;
    end
  end

  always_ff @(posedge g_clk) begin
    if (w_push) fifo_q[wr_ptr_q] <= w_resp;
  end

  always_ff @(posedge g_clk) begin
    if (w_push && dmem_wen && w_in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (dmem_strb[i]) mem_q[w_idx][8*i +: 8] <= dmem_wdata[8*i +: 8];
      end
    end
  end

  assign dmem_recv = (count_q != 2'd0);
  assign {dmem_error, dmem_rdata} = dmem_recv ? fifo_q[rd_ptr_q] : 33'h0;

endmodule
`default_nettype wire

// File: tb/tb_frv_dmem_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_frv_dmem_responder : directed self-checking bench, WAIT_CYCLES 0 and 3.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_frv_dmem_responder;

  localparam logic [31:0] C_BASE = 32'h0001_0000;

  logic        clk = 1'b0;
  logic        rstn;
  logic        a_req, a_wen, a_ack, a_gnt, a_recv, a_err;
  logic [3:0]  a_strb;
  logic [31:0] a_wdata, a_addr, a_rdata;
  logic        b_req, b_wen, b_ack, b_gnt, b_recv, b_err;
  logic [3:0]  b_strb;
  logic [31:0] b_wdata, b_addr, b_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  logic        op_wen   [8];
  logic [3:0]  op_strb  [8];
  logic [31:0] op_addr  [8];
  logic [31:0] op_wdata [8];
  logic        ex_err   [8];
  logic [31:0] ex_rdata [8];

  always #5 clk = ~clk;

  frv_dmem_responder #(.BASE_ADDR(C_BASE), .DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_dut_a (
    .g_clk(clk), .g_resetn(rstn), .dmem_req(a_req), .dmem_wen(a_wen),
    .dmem_strb(a_strb), .dmem_wdata(a_wdata), .dmem_addr(a_addr),
    .dmem_gnt(a_gnt), .dmem_recv(a_recv), .dmem_ack(a_ack),
    .dmem_error(a_err), .dmem_rdata(a_rdata)
  );

  frv_dmem_responder #(.BASE_ADDR(C_BASE), .DEPTH_WORDS(1024), .WAIT_CYCLES(3)) u_dut_b (
    .g_clk(clk), .g_resetn(rstn), .dmem_req(b_req), .dmem_wen(b_wen),
    .dmem_strb(b_strb), .dmem_wdata(b_wdata), .dmem_addr(b_addr),
    .dmem_gnt(b_gnt), .dmem_recv(b_recv), .dmem_ack(b_ack),
    .dmem_error(b_err), .dmem_rdata(b_rdata)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic set_op(input int i, input logic wen, input logic [3:0] strb,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic err, input logic [31:0] rd);
    op_wen[i] = wen; op_strb[i] = strb; op_addr[i] = addr; op_wdata[i] = wdata;
    ex_err[i] = err; ex_rdata[i] = rd;
  endtask

  // Issues n ops back to back on DUT A with ack held high; each response lands one cycle later.
  task automatic run_stream(input int n, input string tag);
    for (int i = 0; i <= n; i++) begin
      @(posedge clk); #1;
      a_ack = 1'b1;
      if (i < n) begin
        a_req = 1'b1; a_wen = op_wen[i]; a_strb = op_strb[i];
        a_addr = op_addr[i]; a_wdata = op_wdata[i];
      end else begin
        a_req = 1'b0;
      end
      @(negedge clk);
      if (i < n) check($sformatf("%s_gnt%0d", tag, i), 32'(a_gnt), 32'd1);
      if (i > 0) begin
        check($sformatf("%s_recv%0d", tag, i-1), 32'(a_recv), 32'd1);
        check($sformatf("%s_err%0d", tag, i-1), 32'(a_err), 32'(ex_err[i-1]));
        check($sformatf("%s_rdata%0d", tag, i-1), a_rdata, ex_rdata[i-1]);
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, "_idle_recv"}, 32'(a_recv), 32'd0);
    check({tag, "_idle_rdata"}, a_rdata, 32'd0);
    check({tag, "_idle_err"}, 32'(a_err), 32'd0);
  endtask

  initial begin
    rstn = 1'b0;
    a_req = 1'b1; a_wen = 1'b1; a_strb = 4'hF; a_addr = C_BASE; a_wdata = 32'h1122_3344; a_ack = 1'b1;
    b_req = 1'b0; b_wen = 1'b0; b_strb = 4'h0; b_addr = C_BASE; b_wdata = 32'h0; b_ack = 1'b1;

    // Reset held with a pending request.
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      check("rst_gnt", 32'(a_gnt), 32'd0);
      check("rst_recv", 32'(a_recv), 32'd0);
      check("rst_rdata", a_rdata, 32'd0);
      check("rst_gnt_b", 32'(b_gnt), 32'd0);
    end
    @(posedge clk); #1 rstn = 1'b1;
    @(negedge clk);
    check("first_gnt", 32'(a_gnt), 32'd1);
    @(posedge clk); #1 a_req = 1'b0;
    @(negedge clk);
    check("first_recv", 32'(a_recv), 32'd1);
    check("first_err", 32'(a_err), 32'd0);
    check("first_rdata", a_rdata, 32'd0);

    // Byte-strobe write then read of the same word.
    set_op(0, 1'b1, 4'hF,    32'h0001_0010, 32'h0000_0000, 1'b0, 32'h0);
    set_op(1, 1'b1, 4'b0101, 32'h0001_0010, 32'hDEAD_BEEF, 1'b0, 32'h0);
    set_op(2, 1'b0, 4'h0,    32'h0001_0010, 32'h0,         1'b0, 32'h00AD_00EF);
    run_stream(3, "strb");

    // Back-pressure: ack low, three reads.
    @(posedge clk); #1 a_ack = 1'b0; a_req = 1'b1; a_wen = 1'b0; a_addr = 32'h0001_0000;
    @(negedge clk); check("bp_gnt0", 32'(a_gnt), 32'd1);
    @(posedge clk); #1 a_addr = 32'h0001_0010;
    @(negedge clk); check("bp_gnt1", 32'(a_gnt), 32'd1);
    check("bp_head0", a_rdata, 32'h1122_3344);
    @(posedge clk); #1 a_addr = 32'h0001_0000;
    @(negedge clk); check("bp_gnt2_full", 32'(a_gnt), 32'd0);
    check("bp_head_stable", a_rdata, 32'h1122_3344);
    @(posedge clk); #1;
    @(negedge clk); check("bp_gnt2_hold", 32'(a_gnt), 32'd0);
    @(posedge clk); #1 a_ack = 1'b1;
    @(negedge clk); check("bp_gnt_popcyc", 32'(a_gnt), 32'd0);
    check("bp_pop_data", a_rdata, 32'h1122_3344);
    @(posedge clk); #1;
    @(negedge clk); check("bp_gnt_after", 32'(a_gnt), 32'd1);
    check("bp_rdata1", a_rdata, 32'h00AD_00EF);
    @(posedge clk); #1 a_req = 1'b0;
    @(negedge clk); check("bp_recv2", 32'(a_recv), 32'd1);
    check("bp_rdata2", a_rdata, 32'h1122_3344);
    @(posedge clk); #1;
    @(negedge clk); check("bp_drained", 32'(a_recv), 32'd0);

    // Out of range on both sides of the window, null-strobe write, array untouched.
    set_op(0, 1'b1, 4'hF, 32'h0001_0FFC, 32'h5A5A_5A5A, 1'b0, 32'h0);
    set_op(1, 1'b1, 4'hF, 32'h0000_0FFC, 32'hCAFE_F00D, 1'b1, 32'h0);
    set_op(2, 1'b1, 4'hF, 32'h0001_1000, 32'hCAFE_F00D, 1'b1, 32'h0);
    set_op(3, 1'b0, 4'h0, 32'h0001_1000, 32'h0,         1'b1, 32'h0);
    set_op(4, 1'b1, 4'h0, 32'h0001_0000, 32'hFFFF_FFFF, 1'b0, 32'h0);
    set_op(5, 1'b0, 4'h0, 32'h0001_0FFC, 32'h0,         1'b0, 32'h5A5A_5A5A);
    set_op(6, 1'b0, 4'h0, 32'h0001_0000, 32'h0,         1'b0, 32'h1122_3344);
    run_stream(7, "oor");

    // Three wait states on DUT B: grant in cycle 3, response in cycle 4.
    @(posedge clk); #1 b_req = 1'b1; b_wen = 1'b1; b_strb = 4'h0; b_addr = C_BASE;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("wait_gnt_c%0d", c), 32'(b_gnt), (c == 3) ? 32'd1 : 32'd0);
      check($sformatf("wait_recv_c%0d", c), 32'(b_recv), 32'd0);
      @(posedge clk); #1;
    end
    b_req = 1'b0;
    @(negedge clk);
    check("wait_recv_c4", 32'(b_recv), 32'd1);
    check("wait_err_c4", 32'(b_err), 32'd0);
    check("wait_gnt_c4", 32'(b_gnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
